shift_exec_16b: RTL and testbench
=================================

SHIFT_EXEC_16B -- requirements
Module: shift_exec_16b

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and shift amount at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operation request.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 in_data  input  16  operand.
REQ-007 in_amt  input  4  shift/rotate amount, 0..15.
REQ-008 in_op  input  2  operation: 00 SLL, 01 SRL, 10 ROL, 11 ROR.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  16  result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-014 Right operations (SRL, ROR) SHALL be computed as reverse, left-shift, reverse, using two reverse_16b instances with revBit = in_op[0] at the input and revBit = the stored op[0] at the output.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 On in_valid && in_ready in IDLE, the block SHALL:
  - load the working register with the optionally reversed in_data;
  - load the counter with in_amt;
  - store in_op;
  - go to SHIFT if in_amt != 0, else go to DONE.
REQ-017 In SHIFT, each cycle SHALL shift the working register left by 1 and decrement the counter.
  - The vacated LSB SHALL be 0 for SLL/SRL.
  - The vacated LSB SHALL be the old MSB for ROL/ROR.
REQ-018 SHIFT SHALL go to DONE in the cycle in which the counter reaches 0.
REQ-019 If the operation is accepted in cycle T, out_valid SHALL first be high in cycle T+1+in_amt.
REQ-020 In DONE, out_valid SHALL be 1 and out_data SHALL equal the optionally reversed working register. Outside DONE, out_valid SHALL be 0.
REQ-021 While out_valid && !out_ready, out_data SHALL be held stable and the FSM SHALL stay in DONE.
REQ-022 On out_valid && out_ready, the FSM SHALL go to IDLE; in_ready SHALL rise the next cycle. There is no same-cycle overlap of result and new request.
REQ-023 in_data, in_amt and in_op SHALL be ignored unless in_valid && in_ready.
REQ-024 An amount of 0 SHALL return the operand unchanged for all ops.

Reset
REQ-025 When rst is asserted, the following SHALL be true at the next clock edge:
  - FSM in IDLE;
  - counter, working register and stored op at 0;
  - out_valid = 0, out_data = 0x0000, busy = 0, in_ready = 1.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the operation and discard its result; no out_valid pulse follows.
REQ-027 Reset SHALL take priority over any handshake sampled in the same cycle.

Configuration
REQ-028 With macro SHIFT_FAST_EN defined, SHIFT SHALL shift by 2 per cycle while the counter is >= 2, and by 1 when the counter is 1.
  - Result latency becomes T+1+ceil(in_amt/2).
  - Results SHALL be identical to the non-fast build.
REQ-029 Without SHIFT_FAST_EN, the block SHALL shift by 1 per cycle as in REQ-017 and REQ-019.

Verification
REQ-030 SLL: in_data 0x0001, in_amt 4, accepted at T -> out_valid at T+5, out_data 0x0010.
REQ-031 SRL: in_data 0x8000, in_amt 15 -> out_data 0x0001 at T+16 (T+9 with SHIFT_FAST_EN).
REQ-032 ROR 0x0001 amt 1 -> 0x8000; ROL 0x8001 amt 0 -> 0x8001 at T+1; ROL 0xF00F amt 4 -> 0x00FF.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data is stable and in_ready stays 0 throughout.
  - When out_ready rises, IDLE follows and in_ready=1 on the next cycle.
REQ-034 Reset mid-SHIFT: issue SRL 0xFFFF amt 12, assert rst at T+3.
  - Next cycle: IDLE, out_data 0x0000, in_ready=1.
  - No out_valid pulse occurs for the aborted operation.
REQ-035 Random sweep: all ops, all amounts 0..15, random data, random out_ready.
  - Every result matches a reference model.
  - Latency matches REQ-019 or REQ-028 for the active configuration.

Source files
------------

// File: rtl/shift_exec_16b.sv
// rtl/shift_exec_16b.sv - 16-bit multi-cycle shift/rotate execution unit with valid/ready handshakes
//
// Ports:
//   clk        single clock, rising-edge state updates
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   block can accept an operation (IDLE only)
//   in_data    16-bit operand
//   in_amt     shift/rotate amount 0..15
//   in_op      00 SLL, 01 SRL, 10 ROL, 11 ROR
//   out_valid  result available (DONE only)
//   out_ready  downstream accepts the result
//   out_data   result, 0x0000 outside DONE
//   busy       high in any state other than IDLE
//
// Build option: define SHIFT_FAST_EN to shift by two positions per cycle
// while at least two positions remain; results are identical either way.

module reverse_16b (
    input  logic        rev_bit,
    input  logic [15:0] din,
    output logic [15:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign dout[i] = rev_bit ? din[15-i] : din[i];
    end
endmodule

module shift_exec_16b (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_amt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] work;
    logic [3:0]  cnt;
    logic [1:0]  op;

    logic [15:0] work_in;
    logic [15:0] work_out;
    logic [15:0] work_step;
    logic [3:0]  cnt_step;
    logic        accept;

    // Right shifts/rotates run as left operations on a bit-reversed word:
    // reverse on the way in (by the request's op) and back on the way out
    // (by the stored op), so the shifter itself only ever moves left.
    reverse_16b u_rev_in (
        .rev_bit (in_op[0]),
        .din     (in_data),
        .dout    (work_in)
    );

    reverse_16b u_rev_out (
        .rev_bit (op[0]),
        .din     (work),
        .dout    (work_out)
    );

    assign accept = in_valid && in_ready;

    // One shift step. op[1] selects rotate: the bits leaving the MSB end
    // re-enter at the LSB end instead of zeros.
`ifdef SHIFT_FAST_EN
    always_comb begin
        work_step = '0;
        cnt_step  = '0;
        if (cnt > 4'd1) begin
            work_step = {work[13:0], op[1] ? work[15:14] : 2'b00};
            cnt_step  = cnt - 4'd2;
        end else begin
            work_step = {work[14:0], op[1] ? work[15] : 1'b0};
            cnt_step  = cnt - 4'd1;
        end
    end
`else
    always_comb begin
        work_step = {work[14:0], op[1] ? work[15] : 1'b0};
        cnt_step  = cnt - 4'd1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (in_amt != 4'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_step == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = (state == DONE) ? work_out : 16'h0000;
    end

    // Datapath: working register, remaining count, captured op
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
            op   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work <= work_in;
                        cnt  <= in_amt;
                        op   <= in_op;
                    end
                end
                SHIFT: begin
                    work <= work_step;
                    cnt  <= cnt_step;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_exec_16b.sv
// tb/tb_shift_exec_16b.sv - self-checking bench for shift_exec_16b

module tb_shift_exec_16b;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    shift_exec_16b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit seen   = 1'b0;
    bit idle_next = 1'b0;

    logic [15:0] exp_q[$];
    int          due_q[$];
    int          acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operand, no reversal tricks.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
        logic [31:0] dd;
        logic [31:0] t;
        dd = {d, d};
        case (op)
            2'd0: return d << a;
            2'd1: return d >> a;
            2'd2: begin t = dd << a; return t[31:16]; end
            default: begin t = dd >> a; return t[15:0]; end
        endcase
    endfunction

    function automatic int latency(input logic [3:0] a);
`ifdef SHIFT_FAST_EN
        return (int'(a) + 1) / 2;
`else
        return int'(a);
`endif
    endfunction

    // Compare process: every cycle, outputs against the model's queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (idle_next) begin
                check("idle_after_release_in_ready", in_ready, 1);
                check("idle_after_release_out_valid", out_valid, 0);
                idle_next = 1'b0;
            end
            check("in_ready_vs_busy", in_ready, !busy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    check("busy_in_done", busy, 1);
                    if (!seen) begin
                        check("latency_cycle", cyc, due_q[0]);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                        idle_next = 1'b1;
                    end
                end
            end else if (exp_q.size() != 0) begin
                if (cyc > acc_q[0]) check("busy_while_shifting", busy, 1);
            end else begin
                check("busy_when_idle", busy, 0);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a,
                        input int hold, input bit has_lit, input logic [15:0] lit);
        int guard;
        logic [15:0] e;
        guard = 0;
        while (!in_ready && guard < 50) begin step(); guard++; end
        if (!in_ready) begin
            check("wait_in_ready_timeout", in_ready, 1);
            return;
        end
        e = model(op, d, a);
        if (has_lit) check("model_literal", e, lit);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        due_q.push_back(cyc + 1 + latency(a));
        step();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_amt   = 4'($urandom);
        in_op    = 2'($urandom);
        guard = 0;
        while (!out_valid && guard < 40) begin step(); guard++; end
        if (!out_valid) begin
            check("wait_out_valid_timeout", out_valid, 1);
            exp_q.delete(); due_q.delete(); acc_q.delete();
            return;
        end
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 16'h0000);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        step();
        mon_en = 1'b1;

        // Directed vectors with hand-computed results
        send(2'd0, 16'h0001, 4'd4,  0, 1, 16'h0010);
        send(2'd1, 16'h8000, 4'd15, 0, 1, 16'h0001);
        send(2'd3, 16'h0001, 4'd1,  0, 1, 16'h8000);
        send(2'd2, 16'h8001, 4'd0,  0, 1, 16'h8001);
        send(2'd2, 16'hF00F, 4'd4,  0, 1, 16'h00FF);
        send(2'd1, 16'hABCD, 4'd0,  0, 1, 16'hABCD);
        send(2'd3, 16'h1234, 4'd8,  0, 1, 16'h3412);
        send(2'd0, 16'hFFFF, 4'd15, 0, 1, 16'h8000);
        send(2'd3, 16'h00F1, 4'd3,  0, 1, 16'h201E);

        // Backpressure: five stalled cycles with the result held
        send(2'd0, 16'h00F0, 4'd3, 5, 1, 16'h0780);

        // Reset in the middle of a shift discards the operation
        mon_en = 1'b0;
        step();
        in_valid = 1'b1; in_op = 2'd1; in_data = 16'hFFFF; in_amt = 4'd12;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_data", out_data, 16'h0000);
        check("abort_out_valid", out_valid, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            check("abort_no_out_valid", out_valid, 0);
        end

        // Reset wins over a request sampled in the same cycle
        step();
        rst = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_data = 16'h0001; in_amt = 4'd0;
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_priority_busy", busy, 0);
        check("rst_priority_out_valid", out_valid, 0);
        step();
        mon_en = 1'b1;

        // Sweep: every op and amount, random data and random stall length
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                d = 16'($urandom);
                send(2'(op), d, 4'(a), $urandom_range(0, 3), 0, 16'h0000);
            end
        end

        step(); step();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
